// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared widths, packet entry layout and PC helper for the instruction fetch sequencer.
package imem_fetch_ctrl_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int FETCH_W     = 64;
  localparam int FETCH_BYTES = 8;
  localparam int ENTRY_W     = FETCH_W + IMEM_ADDR_W;

  typedef struct packed {
    logic [FETCH_W-1:0]     data;
    logic [IMEM_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch address; the 10-bit add wraps 10'h3F8 -> 10'h000 by itself.
  function automatic logic [IMEM_ADDR_W-1:0] next_fetch_pc(input logic [IMEM_ADDR_W-1:0] pc);
    return pc + IMEM_ADDR_W'(FETCH_BYTES);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fetch_fifo.sv
// Packet buffer between the instruction memory response and decode.
// Head is read straight from the storage registers; flush empties it in one edge.
module fetch_fifo
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [AW-1:0]    PTR_MASK = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer and occupancy next-state; flush overrides any push or pop.
  always_comb begin
    do_push_s = push_i & (count_q != CNT_FULL);
    do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}});
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = (wr_ptr_q + AW'(1)) & PTR_MASK;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = (rd_ptr_q + AW'(1)) & PTR_MASK;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the head is masked while empty.
  always_ff @(posedge clock_i) begin
    if (do_push_s && !flush_i && !reset_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign dout_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the 64-bit instruction memory: owns the fetch PC, issues reads
// against buffer credit, and queues returned packets for the dual-issue decoder.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC   = 10'h000,
  parameter int                     FIFO_DEPTH = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   fetch_en_i,
  input  logic                   redirect_i,
  input  logic [IMEM_ADDR_W-1:0] redirect_pc_i,
  output logic                   imem_re_o,
  output logic                   imem_ssr_o,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  input  logic [FETCH_W-1:0]     imem_data_i,
  output logic                   fetch_valid_o,
  input  logic                   fetch_ready_i,
  output logic [FETCH_W-1:0]     fetch_data_o,
  output logic [IMEM_ADDR_W-1:0] fetch_pc_o
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int CREDIT_W = CNT_W + 1;

  logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
  logic                   inflight_q, inflight_d;
  logic [IMEM_ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic [CNT_W-1:0]       count_s;
  logic [CREDIT_W-1:0]    credit_used_s;
  logic                   empty_s;
  logic                   issue_s;
  logic                   push_s;
  logic                   pop_s;
  fetch_entry_t           push_entry_s;
  fetch_entry_t           head_entry_s;

  // Issue/credit decision and PC sequencing; only registered state gates the credit.
  always_comb begin
    credit_used_s = CREDIT_W'(count_s) + CREDIT_W'(inflight_q);
    issue_s       = fetch_en_i & ~redirect_i & ~reset_i &
                    (credit_used_s < CREDIT_W'(FIFO_DEPTH));
    push_s        = inflight_q & ~redirect_i & ~reset_i;
    pop_s         = ~empty_s & fetch_ready_i;
    pc_d          = pc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (issue_s) begin
      pc_d = next_fetch_pc(pc_q);
    end else begin
      pc_d = pc_q;
    end
    if (issue_s) begin
      inflight_pc_d = pc_q;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end
    push_entry_s.data = imem_data_i;
    push_entry_s.pc   = inflight_pc_q;
  end

  // Fetch PC and in-flight tracking registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {IMEM_ADDR_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (redirect_i),
    .push_i  (push_s),
    .din_i   (push_entry_s),
    .pop_i   (pop_s),
    .dout_o  (head_entry_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  // The reset cycle also reads, so the memory's synchronous clear lands on its output register.
  assign imem_re_o     = issue_s | reset_i;
  assign imem_ssr_o    = reset_i;
  assign imem_addr_o   = pc_q;
  assign fetch_valid_o = ~empty_s;
  assign fetch_data_o  = head_entry_s.data;
  assign fetch_pc_o    = head_entry_s.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and scoreboard checks for imem_fetch_ctrl; a second instance starts at 10'h3F0
// to exercise the address wrap.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, redir, rdy;
  logic [9:0]  rpc;

  logic        re, ssr, valid;
  logic [9:0]  addr, fpc;
  logic [63:0] mdata, fdata;
  logic        w_re, w_ssr, w_valid;
  logic [9:0]  w_addr, w_fpc;
  logic [63:0] w_mdata, w_fdata;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [9:0] a);
    return {16'hC0DE, 6'b000000, a, 16'hBEEF, 6'b000000, ~a};
  endfunction

  // Instruction memory models: one-cycle read latency, synchronous clear on ssr.
  always @(posedge clk) begin
    if (ssr) mdata <= 64'h0;
    else if (re) mdata <= pat(addr);
    if (w_ssr) w_mdata <= 64'h0;
    else if (w_re) w_mdata <= pat(w_addr);
  end

  imem_fetch_ctrl #(.RESET_PC(10'h000), .FIFO_DEPTH(4)) dut (
    .clock_i(clk), .reset_i(rst), .fetch_en_i(en), .redirect_i(redir),
    .redirect_pc_i(rpc), .imem_re_o(re), .imem_ssr_o(ssr), .imem_addr_o(addr),
    .imem_data_i(mdata), .fetch_valid_o(valid), .fetch_ready_i(rdy),
    .fetch_data_o(fdata), .fetch_pc_o(fpc));

  imem_fetch_ctrl #(.RESET_PC(10'h3F0), .FIFO_DEPTH(4)) dut_w (
    .clock_i(clk), .reset_i(rst), .fetch_en_i(en), .redirect_i(redir),
    .redirect_pc_i(rpc), .imem_re_o(w_re), .imem_ssr_o(w_ssr), .imem_addr_o(w_addr),
    .imem_data_i(w_mdata), .fetch_valid_o(w_valid), .fetch_ready_i(rdy),
    .fetch_data_o(w_fdata), .fetch_pc_o(w_fpc));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redir = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [9:0] exp_pc;
  logic [9:0] e;
  int         xfers;

  initial begin
    rst = 1'b1; en = 1'b1; redir = 1'b0; rdy = 1'b1; rpc = 10'h000;
    tick();

    // Test 1: streaming with ready held, plus wrap on the 3F0 instance.
    rst = 1'b1; settle();
    check_eq("rst_re", 64'(re), 64'd1);
    check_eq("rst_ssr", 64'(ssr), 64'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check_eq("t1_addr", 64'(addr), 64'(10'(8 * k)));
      check_eq("t4_addr", 64'(w_addr), 64'(10'(10'h3F0 + 10'(8 * k))));
      check_eq("t1_ssr", 64'(ssr), 64'd0);
      if (k < 2) begin
        check_eq("t1_valid0", 64'(valid), 64'd0);
        check_eq("t1_data0", fdata, 64'h0);
        check_eq("t1_pc0", 64'(fpc), 64'h0);
      end else begin
        e = 10'(8 * (k - 2));
        check_eq("t1_valid", 64'(valid), 64'd1);
        check_eq("t1_pc", 64'(fpc), 64'(e));
        check_eq("t1_data", fdata, pat(e));
        e = 10'h3F0 + 10'(8 * (k - 2));
        check_eq("t4_pc", 64'(w_fpc), 64'(e));
        check_eq("t4_data", w_fdata, pat(e));
      end
      tick();
    end

    // Test 2: ready low fills exactly four credits, release drains in order.
    rdy = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      settle();
      check_eq("t2_re_fill", 64'(re), (k < 4) ? 64'd1 : 64'd0);
      tick();
    end
    rdy = 1'b1;
    for (int k = 8; k < 13; k++) begin
      settle();
      check_eq("t2_pc", 64'(fpc), 64'(10'(8 * (k - 8))));
      if (k == 8) check_eq("t2_re_hold", 64'(re), 64'd0);
      if (k == 9) begin
        check_eq("t2_re_resume", 64'(re), 64'd1);
        check_eq("t2_addr_resume", 64'(addr), 64'h020);
      end
      tick();
    end

    // Test 3: redirect with two buffered packets and one read in flight.
    rdy = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    redir = 1'b1; rpc = 10'h100; settle();
    check_eq("t3_re_redir", 64'(re), 64'd0);
    tick();
    redir = 1'b0; rdy = 1'b1; settle();
    check_eq("t3_valid_a", 64'(valid), 64'd0);
    check_eq("t3_addr", 64'(addr), 64'h100);
    check_eq("t3_re", 64'(re), 64'd1);
    tick(); settle();
    check_eq("t3_valid_b", 64'(valid), 64'd0);
    tick(); settle();
    check_eq("t3_valid_c", 64'(valid), 64'd1);
    check_eq("t3_pc_a", 64'(fpc), 64'h100);
    check_eq("t3_data_a", fdata, pat(10'h100));
    tick(); settle();
    check_eq("t3_pc_b", 64'(fpc), 64'h108);
    tick();

    // Test 5: one-cycle reset mid-stream.
    rst = 1'b1; settle();
    check_eq("t5_re", 64'(re), 64'd1);
    check_eq("t5_ssr", 64'(ssr), 64'd1);
    tick();
    rst = 1'b0; settle();
    check_eq("t5_valid", 64'(valid), 64'd0);
    check_eq("t5_pc0", 64'(fpc), 64'h0);
    check_eq("t5_data0", fdata, 64'h0);
    check_eq("t5_addr", 64'(addr), 64'h000);
    tick(); tick(); settle();
    check_eq("t5_valid_b", 64'(valid), 64'd1);
    check_eq("t5_pc", 64'(fpc), 64'h000);
    check_eq("t5_data", fdata, pat(10'h000));
    tick();

    // Test 6: random traffic against a stream scoreboard (consecutive PCs per redirect epoch).
    do_reset();
    exp_pc = 10'h000;
    xfers  = 0;
    for (int c = 0; c < 4000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 29) == 0);
      rpc   = 10'($urandom_range(0, 127)) << 3;
      settle();
      if (ssr !== 1'b0) check_eq("t6_ssr", 64'(ssr), 64'd0);
      if (valid && rdy) begin
        check_eq("t6_pc", 64'(fpc), 64'(exp_pc));
        check_eq("t6_data", fdata, pat(exp_pc));
        exp_pc = exp_pc + 10'h008;
        xfers++;
      end
      if (redir) exp_pc = rpc;
      tick();
    end
    check_eq("t6_progress", 64'(xfers > 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
